// File: rtl/subsystem_eq1_pipe_if.sv
// rtl/subsystem_eq1_pipe_if.sv - sample/result handshake bundle for the eq1 pipeline
interface subsystem_eq1_pipe_if #(
  parameter int N = 16
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] I1;
  logic signed [N-1:0] I2;
  logic signed [N-1:0] I3;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] O_raw;
  logic signed [2*N-1:0] O_full;
  logic                ovf;

  modport master (
    output in_valid, I1, I2, I3, out_ready,
    input  in_ready, out_valid, O_raw, O_full, ovf
  );

  modport slave (
    input  in_valid, I1, I2, I3, out_ready,
    output in_ready, out_valid, O_raw, O_full, ovf
  );
endinterface

// File: rtl/subsystem_eq1_pipe.sv
// rtl/subsystem_eq1_pipe.sv - 3-stage fixed-point O = I3*I3*(1-I1) + I2*I1, optional saturation via EQ1_SAT_EN
module subsystem_eq1_pipe #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input logic                 clk,
  input logic                 rst,
  subsystem_eq1_pipe_if.slave bus
);
  localparam int W = 2 * N;
  localparam logic signed [N-1:0] ONE = N'(1) << FRAC;

  logic                adv;
  logic                v1, v2, v3;
  logic signed [N-1:0] t0, t1;
  logic signed [W-1:0] pb1, pa2, pb2;
  logic signed [N-1:0] raw_q;
  logic signed [W-1:0] full_q;
  logic                ovf_q;

  logic signed [W-1:0] sq, pb_d, pa_d;
  logic signed [N-1:0] t0_d, t1_d, raw_d;
  logic signed [W:0]   sum_d, shifted;
  logic                ovf_d;

  // Single stall signal: every stage moves together or not at all.
  assign adv = !v3 || bus.out_ready;

  assign sq      = W'(bus.I3) * W'(bus.I3);
  assign t0_d    = N'(sq >>> FRAC);
  assign t1_d    = ONE - bus.I1;
  assign pb_d    = W'(bus.I2) * W'(bus.I1);
  assign pa_d    = W'(t0) * W'(t1);
  assign sum_d   = (W+1)'(pa2) + (W+1)'(pb2);
  assign shifted = sum_d >>> FRAC;

  // Fits in N signed bits only if every bit from the N-bit sign position up is a copy of it.
  assign ovf_d = !((&shifted[W:N-1]) || !(|shifted[W:N-1]));

`ifdef EQ1_SAT_EN
  localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};
  assign raw_d = ovf_d ? (shifted[W] ? MIN_N : MAX_N) : shifted[N-1:0];
`else
  assign raw_d = shifted[N-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      t0     <= '0;
      t1     <= '0;
      pb1    <= '0;
      pa2    <= '0;
      pb2    <= '0;
      raw_q  <= '0;
      full_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_valid) begin
        t0  <= t0_d;
        t1  <= t1_d;
        pb1 <= pb_d;
      end
      if (v1) begin
        pa2 <= pa_d;
        pb2 <= pb1;
      end
      // Output registers keep the last real result across bubbles.
      if (v2) begin
        raw_q  <= raw_d;
        full_q <= sum_d[W-1:0];
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;
  assign bus.O_raw     = raw_q;
  assign bus.O_full    = full_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/subsystem_eq1_pipe.md
SUBSYSTEM_EQ1_PIPE -- requirements
Module: subsystem_eq1_pipe

Interface
REQ-001 SHALL have parameter N, default 16, total fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits; legal range 1 <= FRAC < N.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, input sample offered.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts the sample this cycle.
REQ-007 SHALL have ports I1, I2, I3, input, signed N bits each, operands in Q(N,FRAC).
REQ-008 SHALL have port out_valid, output, 1 bit, result presented.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-010 SHALL have port O_raw, output, signed N bits, result in Q(N,FRAC).
REQ-011 SHALL have port O_full, output, signed 2N bits, unshifted low 2N bits of the sum (debug).
REQ-012 SHALL have port ovf, output, 1 bit, the presented result exceeded the signed N-bit range.

Function
REQ-013 SHALL compute O = I3*I3*(1-I1) + I2*I1 over a 3-stage registered pipeline (S1, S2, S3).
REQ-014 S1 SHALL register t0 = (I3*I3 >>> FRAC)[N-1:0], t1 = (ONE - I1)[N-1:0] with ONE = 1<<FRAC, and pB = I2*I1 at full 2N width.
REQ-015 S2 SHALL register pA = t0*t1 at full 2N width and carry pB forward unchanged.
REQ-016 S3 SHALL register sum = pA + pB at 2N+1 width; O_full = sum[2N-1:0]; shifted = sum >>> FRAC (arithmetic).
REQ-017 ovf SHALL be 1 when shifted lies outside [-2^(N-1), 2^(N-1)-1], registered together with the S3 data.
REQ-018 Each stage SHALL carry a valid bit; a transfer occurs on a cycle when valid and ready are both high.
REQ-019 Global advance SHALL be adv = !out_valid || out_ready; all stages load only when adv = 1.
REQ-020 in_ready SHALL equal adv (combinational); a sample is accepted when in_valid && in_ready.
REQ-021 Latency SHALL be 3 cycles from acceptance to out_valid with no stall; throughput 1 sample/cycle.
REQ-022 While out_valid && !out_ready, O_raw, O_full, ovf and out_valid SHALL hold stable.
REQ-023 Bubbles (in_valid = 0) SHALL propagate as valid = 0 and SHALL NOT be presented.
REQ-024 Simultaneous output pop and input accept SHALL be lossless, with no duplicate and no dropped samples.

Reset
REQ-025 While rst = 1, all stage valid bits and out_valid SHALL be 0, and O_raw, O_full and ovf SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight samples; the first output after release SHALL come from a post-reset input.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro EQ1_SAT_EN defined: when ovf = 1, O_raw SHALL saturate to 2^(N-1)-1 if shifted > 0, else to -2^(N-1).
REQ-029 Macro EQ1_SAT_EN undefined: O_raw SHALL be shifted[N-1:0] (wrap); ovf SHALL still report overflow.
REQ-030 O_full and the pipeline timing SHALL be identical with and without EQ1_SAT_EN.

Verification (N=16, FRAC=8)
REQ-031 I1=0x0080, I2=0x0200, I3=0x0100, out_ready=1 -> 3 cycles later out_valid=1, O_raw=0x0180, O_full=0x00018000, ovf=0.
REQ-032 I1=0x0200, I2=0x7FFF, I3=0x0000 -> ovf=1; O_raw=0xFFFE without EQ1_SAT_EN, O_raw=0x7FFF with it.
REQ-033 Back-to-back 8 samples, out_ready=1 -> 8 consecutive out_valid cycles, results in order and matching the reference model.
REQ-034 3 samples accepted, then out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1; outputs stable; after release, 3 results in order with none lost.
REQ-035 rst pulsed while 2 samples are in flight -> out_valid=0, O_raw=0 immediately; no stale output after release; next input produces the correct result 3 cycles after acceptance.
REQ-036 Random in_valid/out_ready over 1000 samples with a scoreboard -> zero mismatches and zero drops.
